// File: rtl/servo_pkg.sv
// ============================================================================
// Module : servo_pkg
// Brief  : Shared widths and channel indices for the servo PWM driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package servo_pkg;

    localparam int ANGLE_W  = 24;
    localparam int NUM_CH   = 3;

    localparam int SHOULDER = 0;
    localparam int ELBOW    = 1;
    localparam int BASE     = 2;

endpackage

`default_nettype wire

// File: rtl/servo_channel.sv
// ============================================================================
// Module : servo_channel
// Brief  : One servo channel: target clamp, per-frame slew register, PWM flop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module servo_channel
    import servo_pkg::*;
#(
    parameter int MIN_W   = 50_000,
    parameter int MAX_W   = 250_000,
    parameter int RESET_W = 150_000,
    parameter int STEP    = 1_000,
    parameter int CNT_W   = 21
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               wrap,
    input  logic [ANGLE_W-1:0] target,
    output logic [ANGLE_W-1:0] width,
    output logic               pwm,
    output logic               match
);

    localparam int CMP_W = (CNT_W > ANGLE_W) ? CNT_W : ANGLE_W;

    localparam logic [ANGLE_W-1:0] C_MIN   = ANGLE_W'(MIN_W);
    localparam logic [ANGLE_W-1:0] C_MAX   = ANGLE_W'(MAX_W);
    localparam logic [ANGLE_W-1:0] C_RESET = ANGLE_W'(RESET_W);
    localparam logic [ANGLE_W-1:0] C_STEP  = ANGLE_W'(STEP);

    logic [ANGLE_W-1:0] w_tgt;
    logic [ANGLE_W-1:0] r_width;
    logic               r_pwm;
    logic [CMP_W-1:0]   w_cnt_x;
    logic [CMP_W-1:0]   w_width_x;

    always_comb begin
        w_tgt = target;
        if (target < C_MIN) begin
            w_tgt = C_MIN;
        end else if (target > C_MAX) begin
            w_tgt = C_MAX;
        end
    end

    assign w_cnt_x   = CMP_W'(cnt);
    assign w_width_x = CMP_W'(r_width);

    // Direction is decided first so the subtraction is always non-negative;
    // a full STEP move stays strictly inside [MIN_W, MAX_W].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_width <= C_RESET;
            r_pwm   <= 1'b0;
        end else begin
            r_pwm <= (w_cnt_x < w_width_x);
            if (wrap) begin
                if (w_tgt > r_width) begin
                    if ((w_tgt - r_width) <= C_STEP) begin
                        r_width <= w_tgt;
                    end else begin
                        r_width <= r_width + C_STEP;
                    end
                end else if ((r_width - w_tgt) <= C_STEP) begin
                    r_width <= w_tgt;
                end else begin
                    r_width <= r_width - C_STEP;
                end
            end
        end
    end

    assign width = r_width;
    assign pwm   = r_pwm;
    assign match = (r_width == w_tgt);

endmodule

`default_nettype wire

// File: rtl/servo_pwm_driver.sv
// ============================================================================
// Module : servo_pwm_driver
// Brief  : Three-channel hobby-servo PWM generator with clamp and frame slew.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int PERIOD  = 2_000_000,
    parameter int MIN_W   = 50_000,
    parameter int MAX_W   = 250_000,
    parameter int RESET_W = 150_000,
    parameter int STEP    = 1_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ANGLE_W-1:0] shoulder_angle,
    input  logic [ANGLE_W-1:0] elbow_angle,
    input  logic [ANGLE_W-1:0] base_angle,
    output logic [2:0]         pwm,
    output logic [ANGLE_W-1:0] shoulder_width,
    output logic [ANGLE_W-1:0] elbow_width,
    output logic [ANGLE_W-1:0] base_width,
    output logic               frame,
    output logic               settled
);

    localparam int               CNT_W  = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame;
    logic               w_wrap;
    logic [ANGLE_W-1:0] w_target [NUM_CH];
    logic [ANGLE_W-1:0] w_width  [NUM_CH];
    logic [NUM_CH-1:0]  w_pwm;
    logic [NUM_CH-1:0]  w_match;

    assign w_wrap = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            r_frame <= (r_cnt == '0);
        end
    end

    assign w_target[SHOULDER] = shoulder_angle;
    assign w_target[ELBOW]    = elbow_angle;
    assign w_target[BASE]     = base_angle;

    // All channels share one wrap strobe so they update on the same edge.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        servo_channel #(
            .MIN_W   (MIN_W),
            .MAX_W   (MAX_W),
            .RESET_W (RESET_W),
            .STEP    (STEP),
            .CNT_W   (CNT_W)
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .cnt    (r_cnt),
            .wrap   (w_wrap),
            .target (w_target[gi]),
            .width  (w_width[gi]),
            .pwm    (w_pwm[gi]),
            .match  (w_match[gi])
        );
    end

    assign pwm            = w_pwm;
    assign shoulder_width = w_width[SHOULDER];
    assign elbow_width    = w_width[ELBOW];
    assign base_width     = w_width[BASE];
    assign frame          = r_frame;
    assign settled        = &w_match;

endmodule

`default_nettype wire
